// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory controller.
// Holds the request size encodings, the controller state enum and the
// alignment rule shared by the controller and anything that needs to
// predict whether a request will be rejected.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // A request is rejected when its address is not a multiple of its
  // access size, or when the size code itself is the reserved one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the MEM pipeline stage and
// the data memory controller.
//   req_valid/req_ready : request handshake (requester -> memory)
//   req_write           : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 reserved
//   req_signed          : sign-extend sub-word loads
//   req_addr            : byte address, ADDR_W bits
//   req_wdata           : right-justified store data
//   rsp_valid/rsp_ready : response handshake (memory -> requester)
//   rsp_rdata           : extended load data, zero for stores and errors
//   rsp_err             : misaligned address or reserved size
// Modports: master = pipeline side, slave = memory side.
interface dmem_if #(
  parameter int ADDR_W = 15
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
//   size, sgn   : access size code and sign-extension request
//   addr_lo     : low two address bits, selecting the starting lane
//   wdata       : right-justified store data from the requester
//   raw         : full little-endian storage word containing the access
//   be          : byte-lane write enables (lane 0 = lowest address)
//   wdata_lane  : store data moved onto the addressed lanes
//   rdata_ext   : addressed bytes moved down to bit 0 and extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  // The starting lane becomes a bit shift: stores move up onto the
  // lanes, loads move down to bit 0 before extension. The reserved size
  // gets no enables and zero data so a stray access can do no harm.
  always_comb begin
    shamt      = {addr_lo, 3'b000};
    shifted    = raw >> shamt;
    be         = 4'b0000;
    wdata_lane = wdata << shamt;
    rdata_ext  = 32'h0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << addr_lo;
        rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = raw;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed little-endian data memory with a
// request/response handshake, programmable wait states and alignment
// error reporting.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : dmem_if slave modport (request and response channels)
// Parameters: DEPTH_BYTES (power of two, >= 4), ADDR_W, LATENCY (1..15).
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 32768,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES),
  parameter int LATENCY     = 1
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus
);

  localparam int         WIDX_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int         NWORDS   = 1 << WIDX_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [31:0]       rdata_q, rdata_n;
  logic              err_q, err_n;
  logic              exec;

  logic              lat_write;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              sel_write;
  logic [1:0]        sel_size;
  logic              sel_signed;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  logic [WIDX_W-1:0] word_idx;
  logic [31:0]       raw_word;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;

  logic [7:0]        mem [4][NWORDS];

  // With a single-cycle latency the access fires on the acceptance edge,
  // so the live request fields drive the datapath while idle; once the
  // request has been taken the latched copy is used instead.
  always_comb begin
    sel_write  = lat_write;
    sel_size   = lat_size;
    sel_signed = lat_signed;
    sel_addr   = lat_addr;
    sel_wdata  = lat_wdata;
    if (state == IDLE) begin
      sel_write  = bus.req_write;
      sel_size   = bus.req_size;
      sel_signed = bus.req_signed;
      sel_addr   = bus.req_addr;
      sel_wdata  = bus.req_wdata;
    end
    word_idx = WIDX_W'(sel_addr >> 2);
    raw_word = {mem[3][word_idx], mem[2][word_idx], mem[1][word_idx], mem[0][word_idx]};
  end

  dmem_lane_align u_align (
    .size       (sel_size),
    .sgn        (sel_signed),
    .addr_lo    (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .raw        (raw_word),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // Next-state logic. The counter holds the wait cycles still to run;
  // the access fires on the edge that would bring it to zero, which puts
  // the response LATENCY edges after acceptance. Rejected requests skip
  // the wait entirely and never touch storage.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    err_n   = err_q;
    exec    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
            err_n   = 1'b1;
            rdata_n = 32'h0;
            state_n = RESP;
          end else if (LATENCY == 1) begin
            exec    = 1'b1;
            state_n = RESP;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          exec    = 1'b1;
          cnt_n   = 4'd0;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rdata_n = 32'h0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (exec) begin
      err_n   = 1'b0;
      rdata_n = sel_write ? 32'h0 : rdata_ext;
    end
  end

  // Control and response registers. Request fields are captured only on
  // acceptance so they stay put however long the wait lasts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      lat_write  <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      if (state == IDLE && bus.req_valid) begin
        lat_write  <= bus.req_write;
        lat_size   <= bus.req_size;
        lat_signed <= bus.req_signed;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
      end
    end
  end

  // Storage is four byte-wide banks sharing one word index. It is not
  // reset; writes are blocked while reset is high so an access caught by
  // reset on its firing edge is dropped rather than half-done.
  always_ff @(posedge clk) begin
    if (exec && sel_write && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[i][word_idx] <= wdata_lane[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: bench for dmem_ctrl. Two controllers are instantiated,
// one with a single-cycle latency and one with four cycles, each driven
// through its own dmem_if. A byte-array model per controller predicts
// load data, error flags and response timing.
module tb_dmem_ctrl;

  logic clk;
  logic rst [2];

  logic        tv_valid  [2];
  logic        tv_write  [2];
  logic [1:0]  tv_size   [2];
  logic        tv_signed [2];
  logic [14:0] tv_addr   [2];
  logic [31:0] tv_wdata  [2];
  logic        tv_rready [2];

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_rdata [2];
  logic        o_err   [2];

  int latOf [2];

  logic [7:0] refm [2][32768];

  int nChecks;
  int nErrors;

  dmem_if #(.ADDR_W(15)) bus1 ();
  dmem_if #(.ADDR_W(15)) bus4 ();

  dmem_ctrl #(.DEPTH_BYTES(32768), .ADDR_W(15), .LATENCY(1)) u_lat1 (
    .clk (clk),
    .rst (rst[0]),
    .bus (bus1)
  );

  dmem_ctrl #(.DEPTH_BYTES(32768), .ADDR_W(15), .LATENCY(4)) u_lat4 (
    .clk (clk),
    .rst (rst[1]),
    .bus (bus4)
  );

  assign bus1.req_valid  = tv_valid[0];
  assign bus1.req_write  = tv_write[0];
  assign bus1.req_size   = tv_size[0];
  assign bus1.req_signed = tv_signed[0];
  assign bus1.req_addr   = tv_addr[0];
  assign bus1.req_wdata  = tv_wdata[0];
  assign bus1.rsp_ready  = tv_rready[0];
  assign o_ready[0] = bus1.req_ready;
  assign o_valid[0] = bus1.rsp_valid;
  assign o_rdata[0] = bus1.rsp_rdata;
  assign o_err[0]   = bus1.rsp_err;

  assign bus4.req_valid  = tv_valid[1];
  assign bus4.req_write  = tv_write[1];
  assign bus4.req_size   = tv_size[1];
  assign bus4.req_signed = tv_signed[1];
  assign bus4.req_addr   = tv_addr[1];
  assign bus4.req_wdata  = tv_wdata[1];
  assign bus4.rsp_ready  = tv_rready[1];
  assign o_ready[1] = bus4.req_ready;
  assign o_valid[1] = bus4.rsp_valid;
  assign o_rdata[1] = bus4.rsp_rdata;
  assign o_err[1]   = bus4.rsp_err;

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference behaviour: bytes stored little-endian in a flat array;
  // a load sums its bytes and, if signed, subtracts 2^(8n) when the top
  // bit is set. Errors leave the array alone and return zero data.
  function automatic void model(input int w, input bit wr, input logic [1:0] sz, input bit sg,
                                input int a, input logic [31:0] wd,
                                output logic [31:0] erd, output bit eerr);
    int n;
    longint v;
    erd  = 32'h0;
    eerr = 1'b0;
    if (sz == 2'b11) begin
      eerr = 1'b1;
      return;
    end
    n = 1 << sz;
    if ((a % n) != 0) begin
      eerr = 1'b1;
      return;
    end
    if (wr) begin
      for (int i = 0; i < n; i++) refm[w][a + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(refm[w][a + i]) << (8 * i);
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      erd = 32'(v);
    end
  endfunction

  // One complete transaction on controller w: present the request,
  // measure the response delay, compare against the model, optionally
  // stall the response for 'hold' cycles while firing ignored requests,
  // then consume it and confirm the controller is idle again.
  task automatic applyStimulus(input int w, input bit wr, input logic [1:0] sz, input bit sg,
                               input logic [14:0] a, input logic [31:0] wd, input int hold,
                               input string tag, output logic [31:0] rd);
    logic [31:0] erd;
    bit          eerr;
    int          elat;
    int          lat;
    logic [31:0] rd0;
    logic        err0;
    model(w, wr, sz, sg, int'(a), wd, erd, eerr);
    elat = eerr ? 1 : latOf[w];
    @(negedge clk);
    tv_rready[w] = (hold == 0);
    tv_write[w]  = wr;
    tv_size[w]   = sz;
    tv_signed[w] = sg;
    tv_addr[w]   = a;
    tv_wdata[w]  = wd;
    tv_valid[w]  = 1'b1;
    checkOutput({tag, "_req_ready"}, 32'(o_ready[w]), 32'd1);
    @(posedge clk);
    #1;
    tv_valid[w] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (o_valid[w]) begin
        lat = k;
      end else begin
        checkOutput({tag, "_busy_ready"}, 32'(o_ready[w]), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(elat));
    checkOutput({tag, "_rdata"}, o_rdata[w], erd);
    checkOutput({tag, "_err"}, 32'(o_err[w]), 32'(eerr));
    rd   = o_rdata[w];
    rd0  = o_rdata[w];
    err0 = o_err[w];
    for (int h = 0; h < hold; h++) begin
      tv_write[w]  = 1'b1;
      tv_size[w]   = 2'b10;
      tv_addr[w]   = 15'h0024;
      tv_wdata[w]  = 32'hFFFF_FFFF;
      tv_valid[w]  = 1'b1;
      @(posedge clk);
      #1;
      tv_valid[w] = 1'b0;
      checkOutput({tag, "_hold_valid"}, 32'(o_valid[w]), 32'd1);
      checkOutput({tag, "_hold_rdata"}, o_rdata[w], rd0);
      checkOutput({tag, "_hold_err"}, 32'(o_err[w]), 32'(err0));
      checkOutput({tag, "_hold_ready"}, 32'(o_ready[w]), 32'd0);
    end
    tv_rready[w] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_valid"}, 32'(o_valid[w]), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(o_ready[w]), 32'd1);
    checkOutput({tag, "_done_rdata"}, o_rdata[w], 32'h0);
    checkOutput({tag, "_done_err"}, 32'(o_err[w]), 32'd0);
  endtask

  task automatic checkResetOutputs(input int w, input string tag);
    checkOutput({tag, "_req_ready"}, 32'(o_ready[w]), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(o_valid[w]), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, o_rdata[w], 32'h0);
    checkOutput({tag, "_rsp_err"}, 32'(o_err[w]), 32'd0);
  endtask

  logic [31:0] rd;
  int          r;
  logic [1:0]  rsz;
  logic [14:0] raddr;

  initial begin
    nChecks  = 0;
    nErrors  = 0;
    latOf[0] = 1;
    latOf[1] = 4;
    for (int w = 0; w < 2; w++) begin
      rst[w]       = 1'b1;
      tv_valid[w]  = 1'b0;
      tv_write[w]  = 1'b0;
      tv_size[w]   = 2'b00;
      tv_signed[w] = 1'b0;
      tv_addr[w]   = 15'h0;
      tv_wdata[w]  = 32'h0;
      tv_rready[w] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs(0, "reset_l1");
    checkResetOutputs(1, "reset_l4");
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    $display("[TB] single-cycle latency directed accesses");
    applyStimulus(0, 1, 2'b10, 0, 15'h0010, 32'hDEADBEEF, 0, "sw_10", rd);
    applyStimulus(0, 0, 2'b10, 0, 15'h0010, 32'h0, 0, "lw_10", rd);
    checkOutput("lw_10_const", rd, 32'hDEADBEEF);
    applyStimulus(0, 0, 2'b00, 1, 15'h0013, 32'h0, 0, "lb_13", rd);
    checkOutput("lb_13_const", rd, 32'hFFFFFFDE);
    applyStimulus(0, 0, 2'b00, 0, 15'h0013, 32'h0, 0, "lbu_13", rd);
    checkOutput("lbu_13_const", rd, 32'h000000DE);
    applyStimulus(0, 0, 2'b01, 1, 15'h0010, 32'h0, 0, "lh_10", rd);
    checkOutput("lh_10_const", rd, 32'hFFFFBEEF);
    applyStimulus(0, 0, 2'b01, 0, 15'h0012, 32'h0, 0, "lhu_12", rd);
    checkOutput("lhu_12_const", rd, 32'h0000DEAD);
    applyStimulus(0, 1, 2'b00, 0, 15'h0011, 32'h00000055, 0, "sb_11", rd);
    applyStimulus(0, 0, 2'b10, 0, 15'h0010, 32'h0, 0, "lw_10_after_sb", rd);
    checkOutput("lw_10_after_sb_const", rd, 32'hDEAD55EF);
    applyStimulus(0, 0, 2'b10, 0, 15'h0012, 32'h0, 0, "err_lw_12", rd);
    applyStimulus(0, 1, 2'b01, 0, 15'h0011, 32'h0000FFFF, 0, "err_sh_11", rd);
    applyStimulus(0, 1, 2'b11, 0, 15'h0000, 32'hFFFFFFFF, 0, "err_size11", rd);
    applyStimulus(0, 0, 2'b10, 0, 15'h0010, 32'h0, 0, "lw_10_after_err", rd);
    checkOutput("lw_10_after_err_const", rd, 32'hDEAD55EF);

    $display("[TB] four-cycle latency: stall, ignored requests, reset abort");
    applyStimulus(1, 1, 2'b10, 0, 15'h0020, 32'h0, 0, "l4_sw_20_zero", rd);
    applyStimulus(1, 1, 2'b10, 0, 15'h0024, 32'hA5A5A5A5, 0, "l4_sw_24", rd);
    applyStimulus(1, 0, 2'b10, 0, 15'h0024, 32'h0, 3, "l4_lw_24_hold", rd);
    checkOutput("l4_lw_24_hold_const", rd, 32'hA5A5A5A5);
    applyStimulus(1, 0, 2'b10, 0, 15'h0024, 32'h0, 0, "l4_lw_24_after_ignored", rd);
    checkOutput("l4_lw_24_after_ignored_const", rd, 32'hA5A5A5A5);

    @(negedge clk);
    tv_write[1]  = 1'b1;
    tv_size[1]   = 2'b10;
    tv_signed[1] = 1'b0;
    tv_addr[1]   = 15'h0020;
    tv_wdata[1]  = 32'h12345678;
    tv_valid[1]  = 1'b1;
    @(posedge clk);
    #1;
    tv_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    #1;
    checkResetOutputs(1, "l4_abort");
    #2;
    rst[1] = 1'b0;
    applyStimulus(1, 0, 2'b10, 0, 15'h0020, 32'h0, 0, "l4_lw_20_after_abort", rd);
    checkOutput("l4_lw_20_after_abort_const", rd, 32'h0);

    $display("[TB] randomized traffic on both controllers");
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        applyStimulus(w, 1, 2'b10, 0, 15'(15'h0100 + 4 * i), $urandom, 0, "rnd_init", rd);
      end
      for (int i = 0; i < 120; i++) begin
        r = int'($urandom_range(0, 9));
        rsz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        raddr = 15'(15'h0100 + $urandom_range(0, 60));
        applyStimulus(w, 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                      raddr, $urandom, 0, "rnd", rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised MIPS data memory with a request/response handshake; successor to the flat byte-array data memory.
- Byte-addressed, little-endian storage: byte 0 of a word sits at the lowest address.
- Supports LB/LBU/LH/LHU/LW and SB/SH/SW, with programmable wait-state latency and misalignment error reporting.
- Sits between the MEM pipeline stage and on-chip storage; the pipeline stalls while req_ready or rsp_valid is pending.

Parameters:
- DEPTH_BYTES, 32768: storage size in bytes; power of two, at least 4.
- ADDR_W, $clog2(DEPTH_BYTES) (15 at default): byte-address width.
- LATENCY, 1: cycles from request acceptance to rsp_valid; range 1..15.

Ports:
- clk  in  1  : single clock, rising edge.
- rst  in  1  : asynchronous, active-high reset.
- req_valid  in  1  : request present.
- req_ready  out  1  : block can accept a request.
- req_write  in  1  : 1 = store, 0 = load.
- req_size  in  2  : 00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  : sign-extend on loads; ignored for word loads and stores.
- req_addr  in  ADDR_W  : byte address.
- req_wdata  in  32  : store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  : response present.
- rsp_ready  in  1  : consumer accepts the response.
- rsp_rdata  out  32  : load result, zero- or sign-extended; 0 for stores and errors.
- rsp_err  out  1  : misaligned address or illegal size.

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0. Memory contents are not reset (undefined).
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid & req_ready at an edge:
  - Latch write, size, signed, addr and wdata.
  - Evaluate alignment: half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always an error.
  - Error: go directly to RESP with rsp_err=1 and rsp_rdata=0. No memory read or write occurs.
  - Otherwise: load counter with LATENCY-1 and go to WAIT, or go to RESP directly if LATENCY=1.
- WAIT: req_ready=0. The counter decrements each cycle; at 0 the access executes on that edge and the FSM moves to RESP.
  - Store: write only the enabled byte lanes. SB writes addr; SH writes addr and addr+1; SW writes addr..addr+3.
  - Load: capture the addressed bytes and extend per size/signed into rsp_rdata.
- Latency: a request accepted at edge N gives rsp_valid high from N+LATENCY. Erroneous requests always respond at N+1.
- RESP: rsp_valid=1; rsp_rdata and rsp_err hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: return to IDLE, clear rsp_valid, rsp_rdata and rsp_err.
  - req_ready stays 0 during RESP; there is no overlap of consecutive requests. Minimum throughput is one access per LATENCY+1 cycles.
- Inputs while req_ready=0 are ignored; the requester must hold req_valid and its fields until acceptance.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-fill.
  - LW returns {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
- Addresses are ADDR_W bits, so there is no out-of-range case. Aligned accesses never wrap past DEPTH_BYTES-1.
- Reset asserted in WAIT or RESP: immediately return to IDLE with outputs at reset values.
  - A store not yet committed (counter not yet at 0 edge) is aborted; memory is unchanged.
  - A completed store stays written.
- Read-after-write: a load accepted after a store's response returns the new data.

Decomposition:
- Package dmem_pkg:
  - Size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11.
  - FSM state enum (IDLE, WAIT, RESP).
  - Function misaligned(size, addr[1:0]).
- One combinational sub-module, dmem_lane_align:
  - Inputs: size, signed, addr[1:0], wdata, raw 32-bit word.
  - Outputs: 4-bit byte enable, lane-shifted write data, extended read data.
- The top holds the FSM, counter and byte array(s).

Test Plan:
- LATENCY=1: SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010 -> rsp_rdata 0xDEADBEEF; rsp_valid exactly 1 cycle after each acceptance; rsp_err=0.
- After the above:
  - LB 0x0013 signed -> 0xFFFFFFDE.
  - LBU 0x0013 -> 0x000000DE.
  - LH 0x0010 signed -> 0xFFFFBEEF.
  - LHU 0x0012 -> 0x0000DEAD.
- SB 0x0011 data 0x55, then LW 0x0010 -> 0xDEAD55EF (other lanes untouched).
- Error cases, each with rsp_err=1, rsp_rdata=0 one cycle after acceptance:
  - LW 0x0012.
  - SH 0x0011.
  - size=11 at 0x0000.
  - Afterwards LW 0x0010 is unchanged.
- LATENCY=4 with rsp_ready held 0 for 3 cycles:
  - rsp_valid rises 4 cycles after acceptance and data stays stable while held.
  - req_ready stays 0 throughout; new req_valid pulses during that time are ignored.
- LATENCY=4: SW 0x0020 data 0x12345678, rst pulsed 2 cycles after acceptance -> outputs reset immediately, req_ready=1; a following LW 0x0020 returns the prior contents (pre-written 0x0 via SW before the test).
